// File: rtl/mpu_mul_seq.sv
// mpu_mul_seq: sequential square-matrix multiplier. It takes one unsigned
// DATA_W x DATA_W multiply-accumulate per clock and iterates k innermost,
// then j, then i over the active dimension n = min(size, MAX_DIM).
// Optional macro MPU_MUL_SATURATE_EN: when it is defined, an element whose
// sum is too large is clamped to 2^DATA_W-1. When it is undefined, the
// element keeps the low DATA_W bits of the sum (wrap).
module mpu_mul_seq #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [7:0]                        size,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_a,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_b,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] result
);

    localparam int CW    = $clog2(MAX_DIM + 1);
    localparam int ACC_W = 2 * DATA_W + 3;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] a_mem   [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0] b_mem   [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0] res_mem [MAX_DIM][MAX_DIM];

    logic [CW-1:0]     n, n_in, i, j, k;
    logic [ACC_W-1:0]  acc, prod, acc_next;
    logic [DATA_W-1:0] wr_val;
    logic              k_last, j_last, i_last;

    // The active dimension is clamped to the largest matrix the block can hold.
    assign n_in = (size > 8'(MAX_DIM)) ? CW'(MAX_DIM) : size[CW-1:0];

    assign k_last   = (k == n - CW'(1));
    assign j_last   = (j == n - CW'(1));
    assign i_last   = (i == n - CW'(1));
    assign prod     = ACC_W'(a_mem[i][k]) * ACC_W'(b_mem[k][j]);
    assign acc_next = acc + prod;

`ifdef MPU_MUL_SATURATE_EN
    assign wr_val = (acc_next > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : acc_next[DATA_W-1:0];
`else
    assign wr_val = acc_next[DATA_W-1:0];
`endif

    // Capture the operands when a start is accepted. Clear the rows and columns outside n in LOAD.
    // NOTE: the operand arrays have no reset. Each operation overwrites them before it reads them, so a reset would add wiring and no behaviour.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    a_mem[r][c] <= matrix_a[(r*MAX_DIM+c)*DATA_W +: DATA_W];
                    b_mem[r][c] <= matrix_b[(r*MAX_DIM+c)*DATA_W +: DATA_W];
                end
            end
        end else if (state == LOAD) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    if (r >= int'(n) || c >= int'(n)) begin
                        a_mem[r][c] <= '0;
                        b_mem[r][c] <= '0;
                    end
                end
            end
        end
    end

    // State register.
    // NOTE: every clocked block uses non-blocking assignments. Then all registers update together, and the order of the blocks in this file cannot change the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and status outputs.
    // NOTE: every output of this block gets a default first. Then no path is left unassigned, and no latch can be inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                busy       = 1'b1;
                next_state = (n == '0) ? DONE : MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (k_last && j_last && i_last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                error      = (n == '0);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: the captured dimension, the accumulator, the loop counters and the result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n   <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    res_mem[r][c] <= '0;
        end else begin
            case (state)
                IDLE: if (start) n <= n_in;
                LOAD: begin
                    acc <= '0;
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                    for (int r = 0; r < MAX_DIM; r++)
                        for (int c = 0; c < MAX_DIM; c++)
                            res_mem[r][c] <= '0;
                end
                MAC: begin
                    if (k_last) begin
                        res_mem[i][j] <= wr_val;
                        acc           <= '0;
                        k             <= '0;
                        if (j_last) begin
                            j <= '0;
                            i <= i + CW'(1);
                        end else begin
                            j <= j + CW'(1);
                        end
                    end else begin
                        acc <= acc_next;
                        k   <= k + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the result registers onto the output bus.
    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            assign result[(r*MAX_DIM+c)*DATA_W +: DATA_W] = res_mem[r][c];
        end
    end

endmodule

// File: tb/tb_mpu_mul_seq.sv
// Testbench for mpu_mul_seq. It drives random and directed operations and
// compares the outputs with a plain-arithmetic reference model.
module tb_mpu_mul_seq;

    localparam int W    = 8;
    localparam int MD   = 5;
    localparam int FLAT = MD * MD * W;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      size;
    logic [FLAT-1:0] matrix_a, matrix_b, result;
    logic            busy, done, error;

    int n_checks = 0;
    int n_errors = 0;

    mpu_mul_seq #(.DATA_W(W), .MAX_DIM(MD)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .size     (size),
        .matrix_a (matrix_a),
        .matrix_b (matrix_b),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLAT-1:0] rand_mat();
        logic [FLAT-1:0] m;
        for (int e = 0; e < MD * MD; e++) m[e*W +: W] = W'($urandom);
        return m;
    endfunction

    // Reference: the matrix product over the active n x n block. Elements outside that block are zero.
    function automatic logic [FLAT-1:0] model_res(input logic [FLAT-1:0] a, input logic [FLAT-1:0] b,
                                                  input logic [7:0] sz);
        logic [FLAT-1:0] r;
        int              n;
        int unsigned     s;
        r = '0;
        n = (int'(sz) > MD) ? MD : int'(sz);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s = s + int'(a[(i*MD+k)*W +: W]) * int'(b[(k*MD+j)*W +: W]);
`ifdef MPU_MUL_SATURATE_EN
                if (s > (1 << W) - 1) s = (1 << W) - 1;
`endif
                r[(i*MD+j)*W +: W] = W'(s);
            end
        end
        return r;
    endfunction

    // One full operation. The task starts just after a rising edge and ends just after a rising edge.
    task automatic run_op(input string tag, input logic [FLAT-1:0] a, input logic [FLAT-1:0] b,
                          input logic [7:0] sz, input bit repulse);
        logic [FLAT-1:0] exp;
        int              n, want_edge, got_edge;
        bit              busy_ok;
        n         = (int'(sz) > MD) ? MD : int'(sz);
        exp       = model_res(a, b, sz);
        want_edge = (n == 0) ? 1 : n * n * n + 1;
        matrix_a  = a;
        matrix_b  = b;
        size      = sz;
        start     = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        matrix_a = rand_mat();
        matrix_b = rand_mat();
        size     = 8'($urandom);
        got_edge = -1;
        busy_ok  = 1'b1;
        for (int e = 1; e <= 600; e++) begin
            if (repulse && e == 5) begin
                start    = 1'b1;
                matrix_a = rand_mat();
                matrix_b = rand_mat();
                size     = 8'd2;
            end
            if (repulse && e == 6) start = 1'b0;
            @(posedge clock); #1;
            if (done) begin
                got_edge = e;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, got_edge, want_edge);
        check({tag, " error"}, error, (sz == 8'd0));
        check({tag, " result"}, result, exp);
        check({tag, " busy_in_done"}, busy, 1'b0);
        check({tag, " busy_during_op"}, busy_ok, 1'b1);
        @(posedge clock); #1;
        check({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [FLAT-1:0] a, b, exp;
        int              dones, first_edge, second_edge;

        reset    = 1'b1;
        start    = 1'b0;
        size     = 8'd0;
        matrix_a = '0;
        matrix_b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset error", error, 1'b0);
        check("reset result", result, '0);
        reset = 1'b0;

        // Identity case. Elements outside the 2x2 block are random and must be masked.
        a = rand_mat();
        b = rand_mat();
        a[0*W +: W] = 8'd1;
        a[1*W +: W] = 8'd2;
        a[(MD+0)*W +: W] = 8'd3;
        a[(MD+1)*W +: W] = 8'd4;
        b[0*W +: W] = 8'd1;
        b[1*W +: W] = 8'd0;
        b[(MD+0)*W +: W] = 8'd0;
        b[(MD+1)*W +: W] = 8'd1;
        exp = '0;
        exp[0*W +: W] = 8'd1;
        exp[1*W +: W] = 8'd2;
        exp[(MD+0)*W +: W] = 8'd3;
        exp[(MD+1)*W +: W] = 8'd4;
        run_op("identity", a, b, 8'd2, 1'b0);
        check("identity const", result, exp);

        // Single element. Every element except (0,0) holds 200.
        a = '0;
        b = '0;
        for (int e = 0; e < MD * MD; e++) begin
            a[e*W +: W] = 8'd200;
            b[e*W +: W] = 8'd200;
        end
        a[7:0] = 8'd3;
        b[7:0] = 8'd4;
        exp = '0;
        exp[7:0] = 8'd12;
        run_op("single", a, b, 8'd1, 1'b0);
        check("single const", result, exp);

        // Overflow case: every element is 255 and n = 5.
        a = '1;
        b = '1;
        run_op("overflow", a, b, 8'd5, 1'b0);
`ifdef MPU_MUL_SATURATE_EN
        check("overflow elem00", result[7:0], 8'd255);
`else
        check("overflow elem00", result[7:0], 8'd5);
`endif

        // Size 0 gives an error. Size 9 is clamped to 5.
        run_op("size0", rand_mat(), rand_mat(), 8'd0, 1'b0);
        run_op("size9", rand_mat(), rand_mat(), 8'd9, 1'b0);

        // A start during MAC is ignored and is not queued.
        run_op("restart", rand_mat(), rand_mat(), 8'd3, 1'b1);
        dones = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock); #1;
            if (done || busy) dones++;
        end
        check("restart no_queue", dones, 0);

        // Start held high: operations run back to back, one IDLE cycle apart.
        a = rand_mat();
        b = rand_mat();
        matrix_a = a;
        matrix_b = b;
        size     = 8'd1;
        start    = 1'b1;
        @(posedge clock); #1;
        dones       = 0;
        first_edge  = -1;
        second_edge = -1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clock); #1;
            if (done) begin
                dones++;
                if (first_edge < 0) first_edge = e;
                else                second_edge = e;
            end
        end
        start = 1'b0;
        check("held count", dones, 2);
        check("held first", first_edge, 2);
        check("held second", second_edge, 6);
        check("held result", result, model_res(a, b, 8'd1));
        repeat (3) @(posedge clock);
        #1;

        // Reset asserted at MAC cycle 10 of an n = 3 operation.
        matrix_a = rand_mat();
        matrix_b = rand_mat();
        size     = 8'd3;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset result", result, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_op("after_reset", rand_mat(), rand_mat(), 8'd3, 1'b0);

        // Random operations over the full size range, including sizes above MAX_DIM.
        for (int t = 0; t < 12; t++)
            run_op("random", rand_mat(), rand_mat(), 8'($urandom_range(0, 9)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
